// File: rtl/i2c_reg_bank_if.sv
// ---------------------------------------------------------------------------
// i2c_reg_bank_if
//   Byte-event link between the I2C peripheral and the register bank.
//   master : I2C peripheral side (drives received byte, toggles, state levels)
//   slave  : register bank side (returns the byte to transmit)
//   Signals:
//     rx_byte     last received byte, stable until the next rx_tgl
//     rx_tgl      toggles once per received data byte (SCL domain)
//     tx_tgl      toggles once per byte sent to the controller (SCL domain)
//     xfer_active high from address ACK until STOP or NACK (SCL domain)
//     i2c_read    R/W bit of the address byte (SCL domain)
//     tx_byte     byte the peripheral shifts out on a read
// ---------------------------------------------------------------------------
interface i2c_reg_bank_if;
    logic [7:0] rx_byte;
    logic       rx_tgl;
    logic       tx_tgl;
    logic       xfer_active;
    logic       i2c_read;
    logic [7:0] tx_byte;

    modport master (
        output rx_byte,
        output rx_tgl,
        output tx_tgl,
        output xfer_active,
        output i2c_read,
        input  tx_byte
    );

    modport slave (
        input  rx_byte,
        input  rx_tgl,
        input  tx_tgl,
        input  xfer_active,
        input  i2c_read,
        output tx_byte
    );
endinterface

// File: rtl/i2c_reg_bank.sv
// ---------------------------------------------------------------------------
// i2c_reg_bank
//   Register bank behind the I2C peripheral. Resynchronises the peripheral's
//   SCL-domain byte events, treats the first written byte of a transaction as
//   a register pointer, then writes or reads bytes with pointer
//   auto-increment. The top register (NREGS-1) is a read-only status slot.
//   Ports:
//     clk, rst    system clock, synchronous active-high reset
//     bus         i2c_reg_bank_if.slave (rx/tx byte events and tx_byte)
//     status_in   value returned on reads of register NREGS-1
//     regs_flat   reg i at bits [8i+7:8i]; status slot reads 0
//     wr_strobe   1-cycle pulse on every register write (incl. status slot)
//     wr_addr     address of the last write
//     ptr         current register pointer
//     err_ptr     sticky flag: out-of-range pointer byte received
// ---------------------------------------------------------------------------
module i2c_reg_bank #(
    parameter int         NREGS       = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_reg_bank_if.slave        bus,
    input  logic [7:0]           status_in,
    output logic [NREGS*8-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [PTR_W-1:0]     wr_addr,
    output logic [PTR_W-1:0]     ptr,
    output logic                 err_ptr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PTR    = 2'd1,
        ST_DATA_W = 2'd2,
        ST_DATA_R = 2'd3
    } state_t;

    // Bit map of the synchronised vector: [0] rx_tgl, [1] tx_tgl,
    // [2] xfer_active, [3] i2c_read. i2c_read needs no history flop.
    logic [3:0]       sync_r [SYNC_STAGES];
    logic [3:0]       synced_s;
    logic [2:0]       hist_r;
    logic             rx_ev_s;
    logic             tx_ev_s;
    logic             start_s;
    logic             stop_s;

    state_t           state_r;
    state_t           state_nx_s;
    logic             ptr_load_s;
    logic             wr_en_s;
    logic             rd_inc_s;
    logic             ptr_ok_s;
    logic [PTR_W-1:0] ptr_inc_s;

    logic [PTR_W-1:0] ptr_r;
    logic [7:0]       regs_r [NREGS];
    logic [7:0]       tx_byte_r;
    logic             wr_strobe_r;
    logic [PTR_W-1:0] wr_addr_r;
    logic             err_ptr_r;

    // Synchroniser chain and history flop for the async inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 4'h0;
            end
            hist_r <= 3'b000;
        end else begin
            sync_r[0] <= {bus.i2c_read, bus.xfer_active, bus.tx_tgl, bus.rx_tgl};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= synced_s[2:0];
        end
    end

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign rx_ev_s  = synced_s[0] ^ hist_r[0];
    assign tx_ev_s  = synced_s[1] ^ hist_r[1];
    assign start_s  = synced_s[2] & ~hist_r[2];
    assign stop_s   = ~synced_s[2] & hist_r[2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: start (even a repeated one) beats everything, then stop
    always_comb begin
        state_nx_s = state_r;
        if (start_s) begin
            state_nx_s = synced_s[3] ? ST_DATA_R : ST_PTR;
        end else if (stop_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_PTR:  state_nx_s = rx_ev_s ? ST_DATA_W : ST_PTR;
                default: state_nx_s = state_r;
            endcase
        end
    end

    // FSM outputs: byte events act in the current state even when stop
    // arrives in the same cycle; a coincident start drops the event
    always_comb begin
        ptr_load_s = 1'b0;
        wr_en_s    = 1'b0;
        rd_inc_s   = 1'b0;
        if (!start_s) begin
            case (state_r)
                ST_PTR:    ptr_load_s = rx_ev_s;
                ST_DATA_W: wr_en_s    = rx_ev_s;
                ST_DATA_R: rd_inc_s   = tx_ev_s;
                default: begin
                    ptr_load_s = 1'b0;
                    wr_en_s    = 1'b0;
                    rd_inc_s   = 1'b0;
                end
            endcase
        end else begin
            ptr_load_s = 1'b0;
            wr_en_s    = 1'b0;
            rd_inc_s   = 1'b0;
        end
    end

    assign ptr_ok_s  = ({24'h000000, bus.rx_byte} < 32'(NREGS));
    assign ptr_inc_s = (ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);

    // Register pointer and sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r     <= {PTR_W{1'b0}};
            err_ptr_r <= 1'b0;
        end else if (ptr_load_s) begin
            ptr_r     <= ptr_ok_s ? bus.rx_byte[PTR_W-1:0] : {PTR_W{1'b0}};
            err_ptr_r <= err_ptr_r | ~ptr_ok_s;
        end else if (wr_en_s || rd_inc_s) begin
            ptr_r     <= ptr_inc_s;
        end
    end

    // Register array; the status slot is never written and holds zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= (i == NREGS - 1) ? 8'h00 : RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NREGS - 1; i++) begin
                if (wr_en_s && (ptr_r == PTR_W'(i))) begin
                    regs_r[i] <= bus.rx_byte;
                end
            end
        end
    end

    // Write strobe and address, raised for status-slot writes too
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= {PTR_W{1'b0}};
        end else begin
            wr_strobe_r <= wr_en_s;
            if (wr_en_s) begin
                wr_addr_r <= ptr_r;
            end
        end
    end

    // Registered transmit byte follows the pointer one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_byte_r <= 8'h00;
        end else begin
            tx_byte_r <= (ptr_r == LAST_PTR) ? status_in : regs_r[ptr_r];
        end
    end

    // Flat view of the register array for fabric logic
    always_comb begin
        regs_flat = {(NREGS*8){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[i*8 +: 8] = (i == NREGS - 1) ? 8'h00 : regs_r[i];
        end
    end

    assign bus.tx_byte = tx_byte_r;
    assign wr_strobe   = wr_strobe_r;
    assign wr_addr     = wr_addr_r;
    assign ptr         = ptr_r;
    assign err_ptr     = err_ptr_r;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_bank
//   Directed self-checking bench for i2c_reg_bank. Expected register
//   contents are kept in exp_r and set by hand at each step.
// ---------------------------------------------------------------------------
module tb_i2c_reg_bank;

    logic          clk;
    logic          rst;
    logic [7:0]    status_in;
    logic [127:0]  regs_flat;
    logic          wr_strobe;
    logic [3:0]    wr_addr;
    logic [3:0]    ptr;
    logic          err_ptr;

    int            errors;
    int            checks;
    int            strobe_cnt;
    logic [3:0]    strobe_log [$];
    logic [7:0]    exp_r [16];

    i2c_reg_bank_if bus ();

    i2c_reg_bank #(
        .NREGS       (16),
        .PTR_W       (4),
        .SYNC_STAGES (2),
        .RESET_VAL   (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .status_in (status_in),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .ptr       (ptr),
        .err_ptr   (err_ptr)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every write strobe, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_log.push_back(wr_addr);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] flat_exp();
        logic [127:0] f;
        f = 128'h0;
        for (int i = 0; i < 16; i++) begin
            f[i*8 +: 8] = exp_r[i];
        end
        return f;
    endfunction

    task automatic send_rx(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_tgl  = ~bus.rx_tgl;
        cycles(6);
    endtask

    task automatic send_tx();
        bus.tx_tgl = ~bus.tx_tgl;
        cycles(6);
    endtask

    task automatic xfer_start(input logic rd);
        bus.i2c_read = rd;
        cycles(1);
        bus.xfer_active = 1'b1;
        cycles(6);
    endtask

    task automatic xfer_stop();
        bus.xfer_active = 1'b0;
        cycles(6);
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        strobe_cnt      = 0;
        rst             = 1'b1;
        status_in       = 8'hC7;
        bus.rx_byte     = 8'h00;
        bus.rx_tgl      = 1'b0;
        bus.tx_tgl      = 1'b0;
        bus.xfer_active = 1'b0;
        bus.i2c_read    = 1'b0;
        for (int i = 0; i < 16; i++) exp_r[i] = 8'h00;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Reset state
        check("rst_ptr",     128'(ptr),         128'h0);
        check("rst_tx",      128'(bus.tx_byte), 128'h0);
        check("rst_strobe",  128'(wr_strobe),   128'h0);
        check("rst_wraddr",  128'(wr_addr),     128'h0);
        check("rst_err",     128'(err_ptr),     128'h0);
        check("rst_regs",    regs_flat,         128'h0);

        // Write ptr 3, data A5 5A
        xfer_start(1'b0);
        send_rx(8'h03);
        send_rx(8'hA5);
        send_rx(8'h5A);
        xfer_stop();
        exp_r[3] = 8'hA5;
        exp_r[4] = 8'h5A;
        check("w1_regs",     regs_flat,              flat_exp());
        check("w1_ptr",      128'(ptr),              128'h5);
        check("w1_strobes",  128'(strobe_cnt),       128'd2);
        check("w1_addr0",    128'(strobe_log[0]),    128'h3);
        check("w1_addr1",    128'(strobe_log[1]),    128'h4);

        // Write across the status slot with wrap
        xfer_start(1'b0);
        send_rx(8'h0E);
        send_rx(8'h11);
        send_rx(8'h22);
        send_rx(8'h33);
        xfer_stop();
        exp_r[14] = 8'h11;
        exp_r[0]  = 8'h33;
        check("w2_regs",     regs_flat,              flat_exp());
        check("w2_ptr",      128'(ptr),              128'h1);
        check("w2_strobes",  128'(strobe_cnt),       128'd5);
        check("w2_addr_st",  128'(strobe_log[3]),    128'hF);
        check("w2_addr_wr",  128'(strobe_log[4]),    128'h0);

        // Preload reg2, then set ptr 2 and read with auto-increment
        xfer_start(1'b0);
        send_rx(8'h02);
        send_rx(8'h77);
        xfer_stop();
        exp_r[2] = 8'h77;
        xfer_start(1'b0);
        send_rx(8'h02);
        xfer_stop();
        check("r_ptr_set",   128'(ptr),              128'h2);
        xfer_start(1'b1);
        check("r_tx0",       128'(bus.tx_byte),      128'h77);
        send_tx();
        check("r_tx1",       128'(bus.tx_byte),      128'hA5);
        send_tx();
        check("r_tx2",       128'(bus.tx_byte),      128'h5A);
        send_tx();
        check("r_tx3",       128'(bus.tx_byte),      128'h00);
        check("r_ptr",       128'(ptr),              128'h5);
        send_rx(8'h99);
        check("r_rx_ign_p",  128'(ptr),              128'h5);
        check("r_rx_ign_s",  128'(strobe_cnt),       128'd6);
        check("r_rx_ign_r",  regs_flat,              flat_exp());
        xfer_stop();

        // Status slot read
        xfer_start(1'b0);
        send_rx(8'h0F);
        xfer_stop();
        xfer_start(1'b1);
        check("st_tx",       128'(bus.tx_byte),      128'hC7);
        status_in = 8'h3C;
        cycles(2);
        check("st_tx_upd",   128'(bus.tx_byte),      128'h3C);
        send_tx();
        check("st_wrap_ptr", 128'(ptr),              128'h0);
        check("st_wrap_tx",  128'(bus.tx_byte),      128'h33);
        xfer_stop();
        bus.i2c_read = 1'b0;

        // Out-of-range pointer
        xfer_start(1'b0);
        send_rx(8'h40);
        check("oor_ptr",     128'(ptr),              128'h0);
        check("oor_err",     128'(err_ptr),          128'h1);
        send_rx(8'h55);
        xfer_stop();
        exp_r[0] = 8'h55;
        check("oor_regs",    regs_flat,              flat_exp());
        xfer_start(1'b0);
        send_rx(8'h01);
        xfer_stop();
        check("oor_sticky",  128'(err_ptr),          128'h1);
        check("oor_ptr2",    128'(ptr),              128'h1);

        // rx toggle and stop on the same clock
        xfer_start(1'b0);
        send_rx(8'h06);
        bus.rx_byte     = 8'h9C;
        bus.rx_tgl      = ~bus.rx_tgl;
        bus.xfer_active = 1'b0;
        cycles(6);
        exp_r[6] = 8'h9C;
        check("sc_regs",     regs_flat,              flat_exp());
        check("sc_ptr",      128'(ptr),              128'h7);
        check("sc_strobes",  128'(strobe_cnt),       128'd8);
        send_rx(8'h44);
        check("idle_regs",   regs_flat,              flat_exp());
        check("idle_ptr",    128'(ptr),              128'h7);
        check("idle_strb",   128'(strobe_cnt),       128'd8);

        // Reset in the middle of a write transaction
        xfer_start(1'b0);
        send_rx(8'h08);
        send_rx(8'hAB);
        check("mr_pre_ptr",  128'(ptr),              128'h9);
        check("mr_pre_strb", 128'(strobe_cnt),       128'd9);
        rst             = 1'b1;
        bus.xfer_active = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(6);
        check("mr_ptr",      128'(ptr),              128'h0);
        check("mr_regs",     regs_flat,              128'h0);
        check("mr_tx",       128'(bus.tx_byte),      128'h0);
        check("mr_err",      128'(err_ptr),          128'h0);
        check("mr_wraddr",   128'(wr_addr),          128'h0);
        check("mr_strobe",   128'(wr_strobe),        128'h0);
        send_rx(8'h12);
        check("mr_ign_ptr",  128'(ptr),              128'h0);
        check("mr_ign_regs", regs_flat,              128'h0);
        check("mr_ign_strb", 128'(strobe_cnt),       128'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
